// File: rtl/regfile_pkg.sv
// Shared register-file types and sizes, also used by the decode and writeback stages.
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_if.sv
// Register-file access bus: one writeback write port and two decode read ports.
interface regfile_if;
  import regfile_pkg::*;

  logic      we;
  reg_addr_t wa;
  reg_data_t wd;
  reg_addr_t ra1;
  reg_addr_t ra2;
  reg_data_t rd1;
  reg_data_t rd2;

  modport master (
    output we, wa, wd, ra1, ra2,
    input  rd1, rd2
  );

  modport slave (
    input  we, wa, wd, ra1, ra2,
    output rd1, rd2
  );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: x0 masking plus optional write-through forwarding.
// Forwarding is compiled in only when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
  import regfile_pkg::*;
(
  input  reg_addr_t ra_i,
  input  reg_data_t reg_val_i,
`ifdef REGFILE_BYPASS_EN
  input  logic      rst_i,
  input  logic      we_i,
  input  reg_addr_t wa_i,
  input  reg_data_t wd_i,
`endif
  output reg_data_t rd_o
);

`ifdef REGFILE_BYPASS_EN
  logic fwd_hit;

  // Forward the in-flight writeback value so decode need not wait a cycle.
  assign fwd_hit = we_i && !rst_i && (wa_i != ZERO_REG) && (wa_i == ra_i);

  always_comb begin
    rd_o = reg_val_i;
    if (ra_i == ZERO_REG) begin
      rd_o = '0;
    end else if (fwd_hit) begin
      rd_o = wd_i;
    end
  end
`else
  assign rd_o = (ra_i == ZERO_REG) ? '0 : reg_val_i;
`endif

endmodule

// File: rtl/regfile.sv
// RISC-V integer register file: 32 x 32-bit, two async read ports, one sync write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  reg_data_t regs_q [NREGS];
  reg_data_t regs_d [NREGS];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_comb begin
    regs_d = regs_q;
    if (bus.we && (bus.wa != ZERO_REG)) begin
      regs_d[bus.wa] = bus.wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_rd_port u_rd_port1 (
    .ra_i      (bus.ra1),
    .reg_val_i (regs_q[bus.ra1]),
`ifdef REGFILE_BYPASS_EN
    .rst_i     (rst),
    .we_i      (bus.we),
    .wa_i      (bus.wa),
    .wd_i      (bus.wd),
`endif
    .rd_o      (bus.rd1)
  );

  regfile_rd_port u_rd_port2 (
    .ra_i      (bus.ra2),
    .reg_val_i (regs_q[bus.ra2]),
`ifdef REGFILE_BYPASS_EN
    .rst_i     (rst),
    .we_i      (bus.we),
    .wa_i      (bus.wa),
    .wd_i      (bus.wd),
`endif
    .rd_o      (bus.rd2)
  );

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; expectations follow REGFILE_BYPASS_EN.
module tb_regfile;
  import regfile_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  regfile_if rf_if ();

  regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; inputs change and outputs settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input reg_addr_t a, input reg_data_t d);
    rf_if.we = 1'b1;
    rf_if.wa = a;
    rf_if.wd = d;
    step();
    rf_if.we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rf_if.we = 1'b1;
    rf_if.wa = 5'd9;
    rf_if.wd = 32'hCAFE_F00D;
    step();
    rst = 1'b0;
    rf_if.we = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      rf_if.ra1 = reg_addr_t'(i);
      rf_if.ra2 = reg_addr_t'(NREGS - 1 - i);
      #1;
      checks++;
      if (rf_if.rd1 !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_rd1[%0d]: got %h expected %h", i, rf_if.rd1, 32'h0);
      end
      checks++;
      if (rf_if.rd2 !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_rd2[%0d]: got %h expected %h", NREGS - 1 - i, rf_if.rd2, 32'h0);
      end
    end
  endtask

  task automatic test_write_read();
    do_write(5'd5, 32'd99);
    do_write(5'd10, 32'd12345);
    rf_if.ra1 = 5'd5;
    rf_if.ra2 = 5'd10;
    #1;
    checks++;
    if (rf_if.rd1 !== 32'd99) begin
      errors++;
      $display("[TB] FAIL write_read_r5: got %0d expected %0d", rf_if.rd1, 99);
    end
    checks++;
    if (rf_if.rd2 !== 32'd12345) begin
      errors++;
      $display("[TB] FAIL write_read_r10: got %0d expected %0d", rf_if.rd2, 12345);
    end
  endtask

  task automatic test_x0();
    rf_if.we = 1'b1;
    rf_if.wa = 5'd0;
    rf_if.wd = 32'hDEAD_BEEF;
    rf_if.ra1 = 5'd0;
    rf_if.ra2 = 5'd0;
    #1;
    checks++;
    if (rf_if.rd2 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL x0_no_forward: got %h expected %h", rf_if.rd2, 32'h0);
    end
    step();
    rf_if.we = 1'b0;
    #1;
    checks++;
    if (rf_if.rd1 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL x0_after_write: got %h expected %h", rf_if.rd1, 32'h0);
    end
  endtask

  task automatic test_same_cycle();
    reg_data_t exp_pre;
    do_write(5'd7, 32'h11);
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'h22;
`else
    exp_pre = 32'h11;
`endif
    rf_if.we = 1'b1;
    rf_if.wa = 5'd7;
    rf_if.wd = 32'h22;
    rf_if.ra1 = 5'd7;
    rf_if.ra2 = 5'd5;
    #1;
    checks++;
    if (rf_if.rd1 !== exp_pre) begin
      errors++;
      $display("[TB] FAIL same_cycle_pre: got %h expected %h", rf_if.rd1, exp_pre);
    end
    checks++;
    if (rf_if.rd2 !== 32'd99) begin
      errors++;
      $display("[TB] FAIL same_cycle_other: got %h expected %h", rf_if.rd2, 32'd99);
    end
    step();
    rf_if.we = 1'b0;
    #1;
    checks++;
    if (rf_if.rd1 !== 32'h22) begin
      errors++;
      $display("[TB] FAIL same_cycle_post: got %h expected %h", rf_if.rd1, 32'h22);
    end
  endtask

  task automatic test_we_low();
    rf_if.we = 1'b0;
    rf_if.wa = 5'd12;
    rf_if.wd = 32'hFFFF_FFFF;
    rf_if.ra1 = 5'd12;
    rf_if.ra2 = 5'd12;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (rf_if.rd1 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL we_low_r12: got %h expected %h", rf_if.rd1, 32'h0);
    end
    rf_if.ra1 = 5'd10;
    rf_if.ra2 = 5'd10;
    #1;
    checks++;
    if (rf_if.rd1 !== 32'd12345) begin
      errors++;
      $display("[TB] FAIL dual_same_rd1: got %0d expected %0d", rf_if.rd1, 12345);
    end
    checks++;
    if (rf_if.rd2 !== 32'd12345) begin
      errors++;
      $display("[TB] FAIL dual_same_rd2: got %0d expected %0d", rf_if.rd2, 12345);
    end
  endtask

  task automatic test_reset_priority();
    do_write(5'd3, 32'hAA);
    rst = 1'b1;
    rf_if.we = 1'b1;
    rf_if.wa = 5'd3;
    rf_if.wd = 32'h55;
    rf_if.ra1 = 5'd3;
    rf_if.ra2 = 5'd10;
    #1;
    checks++;
    if (rf_if.rd1 !== 32'hAA) begin
      errors++;
      $display("[TB] FAIL rst_no_forward: got %h expected %h", rf_if.rd1, 32'hAA);
    end
    step();
    rst = 1'b0;
    rf_if.we = 1'b0;
    #1;
    checks++;
    if (rf_if.rd1 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rst_priority_r3: got %h expected %h", rf_if.rd1, 32'h0);
    end
    checks++;
    if (rf_if.rd2 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rst_clears_r10: got %h expected %h", rf_if.rd2, 32'h0);
    end
    do_write(5'd3, 32'h55);
    checks++;
    if (rf_if.rd1 !== 32'h55) begin
      errors++;
      $display("[TB] FAIL post_rst_write: got %h expected %h", rf_if.rd1, 32'h55);
    end
  endtask

  task automatic test_back_to_back();
    reg_data_t exp;
    for (int i = 1; i < NREGS; i++) begin
      rf_if.we = 1'b1;
      rf_if.wa = reg_addr_t'(i);
      rf_if.wd = 32'h1000_0000 + i * 3 + 1;
      step();
    end
    rf_if.we = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      rf_if.ra1 = reg_addr_t'(i);
      rf_if.ra2 = reg_addr_t'(NREGS - 1 - i);
      exp = (i == 0) ? 32'h0 : 32'h1000_0000 + i * 3 + 1;
      #1;
      checks++;
      if (rf_if.rd1 !== exp) begin
        errors++;
        $display("[TB] FAIL b2b_rd1[%0d]: got %h expected %h", i, rf_if.rd1, exp);
      end
      exp = (i == NREGS - 1) ? 32'h0 : 32'h1000_0000 + (NREGS - 1 - i) * 3 + 1;
      checks++;
      if (rf_if.rd2 !== exp) begin
        errors++;
        $display("[TB] FAIL b2b_rd2[%0d]: got %h expected %h", NREGS - 1 - i, rf_if.rd2, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rf_if.we = 1'b0;
    rf_if.wa = '0;
    rf_if.wd = '0;
    rf_if.ra1 = '0;
    rf_if.ra2 = '0;
    test_reset();
    test_write_read();
    test_x0();
    test_same_cycle();
    test_we_low();
    test_reset_priority();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- RISC-V integer register file for the pipelined core's decode stage.
- Provides 32 architectural registers of 32 bits each, with two combinational read ports and one synchronous write port.
- Register x0 is hardwired to zero.
- Read data feeds the ID/EX operands; the write port is driven by the writeback stage.

Parameters:
- XLEN, 32: register data width in bits.
- NREGS, 32: number of architectural registers.
- AW, 5: register address width; must equal clog2(NREGS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable.
- wa  input  AW  write address.
- wd  input  XLEN  write data.
- ra1  input  AW  read address, port 1.
- ra2  input  AW  read address, port 2.
- rd1  output  XLEN  read data, port 1.
- rd2  output  XLEN  read data, port 2.

Behaviour:
- Storage: NREGS x XLEN array, with index 0 treated as constant zero.
- Reset: on a rising clk edge with rst=1, registers 1..NREGS-1 clear to 0. Reset takes priority over a simultaneous write; the write is dropped.
- Write: on a rising clk edge with rst=0, we=1 and wa!=0, reg[wa] takes wd. The new value is visible on the read ports immediately after that edge.
- Write to x0: ignored silently; no state change.
- we=0: no state change, regardless of wa and wd.
- Read: purely combinational, zero latency. rdN = 0 when raN==0, otherwise reg[raN].
- Both ports may read the same address simultaneously; each returns identical data.
- Same-cycle read of a register being written (raN==wa, we=1, before the edge): returns the old value. The bypass feature below changes this.
- After reset and before any write, every read returns 0.
- Unknown or X addresses carry no special requirement; reads of in-range addresses never produce X after reset.
- No handshake and no stall; the block accepts one write per cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When we=1, wa!=0 and raN==wa, rdN = wd combinationally in the same cycle. This lets writeback and decode share a cycle without a hazard bubble.
- Forwarding never applies for address 0; rdN stays 0.
- Forwarding is suppressed while rst=1.
- Not defined: reads return stored contents only; same-cycle reads see the old value.
- The write behaviour is identical in both builds.

Decomposition:
- Package regfile_pkg holds XLEN, NREGS, AW, ZERO_REG=0, and typedefs reg_addr_t (AW bits) and reg_data_t (XLEN bits). These are shared with the decode and writeback stages.
- Sub-module regfile_rd_port, instantiated twice: takes the address, the array value, and the write-port signals. It performs zero-masking and the optional bypass mux.

Test Plan:
- Reset then read all: rst=1 for one edge, sweep ra1/ra2 over 0..31 -> rd1=rd2=0 for every address.
- Write and read back: we=1 wa=5 wd=99, one edge; then we=1 wa=10 wd=12345, one edge; then we=0, ra1=5, ra2=10 -> rd1=99, rd2=12345.
- x0 protection: we=1 wa=0 wd=0xDEADBEEF, one edge; ra1=0 -> rd1=0. Also check ra2=0 -> rd2=0 with REGFILE_BYPASS_EN defined.
- Same-cycle read/write: reg7 holds 0x11; drive we=1 wa=7 wd=0x22 with ra1=7 before the edge -> rd1=0x11 without the macro, 0x22 with it. After the edge rd1=0x22 in both builds.
- Reset priority and mid-operation reset: reg3=0xAA; assert rst=1 together with we=1 wa=3 wd=0x55, one edge -> rd1(ra1=3)=0. Then write reg3=0x55 with rst=0 -> reads 0x55.
- Write enable low: we=0 wa=12 wd=0xFFFFFFFF, several edges -> reg12 unchanged (0). Dual-port same address ra1=ra2=10 -> both return 12345.
